logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised successor to the team's 2-bit-select single-bit gate selector.
- Computes one of 8 bitwise logic ops on WIDTH-bit operands.
- Output is registered, with valid/ready handshakes on both sides.
- Adds an accumulate mode: operand B is replaced by the previous result, so ops can chain across transactions. Sits between a command source and any downstream consumer in the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..64).
- ACC_RST, 0, value loaded into the accumulator on reset and on clear (WIDTH bits, zero-extended).

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept an input this cycle
- in_op  in  3  operation code (see Behaviour)
- in_acc  in  1  when 1, operand B is taken from the accumulator instead of in_b
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- acc_clr  in  1  synchronous accumulator clear to ACC_RST
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  result
- acc_q  out  WIDTH  current accumulator value, for debug

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, acc=ACC_RST. in_ready reads 1 once out_valid=0.
- Op codes:
  - 000 NOT A
  - 001 A AND B
  - 010 A OR B
  - 011 A XOR B
  - 100 NAND
  - 101 NOR
  - 110 XNOR
  - 111 PASS A
- Codes 000–011 match the legacy selector encoding, extended to two's-width buses. All ops are bitwise; no carries; result width is WIDTH.
- Operand select: B_eff = in_acc ? acc : in_b.
- Ready rule: in_ready = !out_valid || out_ready. This is a single output register; full throughput, no bubble under continuous ready.
- Accept: accept = in_valid && in_ready. On accept:
  - out_data <= f(in_op, in_a, B_eff)
  - out_valid <= 1
  - acc <= the same result
- Latency: exactly 1 cycle from accept to out_valid.
- No accept and out_ready=1: out_valid <= 0, and out_data holds its last value.
- Backpressure: out_valid=1 and out_ready=0 forces in_ready=0. out_data and out_valid must hold stable until taken.
- acc_clr:
  - With no accept that cycle: acc <= ACC_RST.
  - Same cycle as an accept: the clear applies to the accumulator read. B_eff uses ACC_RST when in_acc=1, and acc then updates to the new result (result wins).
- acc_clr has no effect on out_valid or out_data.
- Back-to-back in_acc transactions use the result of the immediately preceding accepted transaction. This holds whether or not that result has been consumed downstream.
- Reset mid-transaction discards any held result. out_valid drops asynchronously.
- in_valid may be asserted while rst_n is low; it is ignored until reset is released.

Optional Feature:
- Macro: LOGIC_UNIT_FLAGS_EN.
- Defined: adds outputs out_zero (1 bit, result==0) and out_par (1 bit, XOR-reduce of result). Both are registered alongside out_data on accept, reset to out_zero=1, out_par=0, and are held under backpressure.
- Not defined: these ports and their registers are absent. All other behaviour is identical.

Decomposition:
- Package logic_unit_pkg:
  - 3-bit op enum with the 8 codes above (OP_NOT, OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_PASSA).
  - OP_W=3 constant.
- Sub-module logic_unit_core: purely combinational WIDTH-parametrised op evaluator (op, a, b -> y). Instantiated once.
- Handshake, accumulator and flags live in logic_unit_pipe.

Test Plan:
- Reset/ops: WIDTH=8, out_ready=1, A=8'hF0, B=8'hCC, cycle op 000..111 one per cycle. Expected out_data 0F, C0, FC, 3C, 3F, 03, C3, F0, each 1 cycle after accept; out_valid is continuous.
- Backpressure: hold out_ready=0 for 3 cycles after a result is produced. Expect in_ready=0, out_data stable, no extra accept. Release: the next input is accepted the same cycle the result is taken.
- Accumulate chain:
  - Reset (acc=00), OR A=8'h01 acc=1 -> 01.
  - OR A=8'h02 acc=1 -> 03.
  - XOR A=8'hFF acc=1 -> FC.
  - acc_q tracks each result.
- acc_clr collision: acc=8'hAA, acc_clr=1 with AND A=8'hFF acc=1 in the same cycle -> out_data=00 (ACC_RST), acc=00. acc_clr alone with acc=8'h55 -> acc=00, out unchanged.
- Async reset mid-hold: out_valid=1 under out_ready=0, pulse rst_n low between clock edges. Expect out_valid=0 and acc=ACC_RST immediately; with the flags macro, out_zero=1 and out_par=0.
- Width sweep: WIDTH=1 and WIDTH=64 with the same op sequence. At WIDTH=1, results match the legacy 1-bit selector truth table for codes 000–011 across all A/B combinations.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared op encoding for the logic unit pipeline.
// Codes 000-011 keep the legacy gate-selector encoding.
package logic_unit_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOT   = 3'b000,
      OP_AND   = 3'b001,
      OP_OR    = 3'b010,
      OP_XOR   = 3'b011,
      OP_NAND  = 3'b100,
      OP_NOR   = 3'b101,
      OP_XNOR  = 3'b110,
      OP_PASSA = 3'b111
   } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise op evaluator: y = f(op, a, b), WIDTH bits wide.
module logic_unit_core
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      unique case (op)
         OP_NOT:   y = ~a;
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_XOR:   y = a ^ b;
         OP_NAND:  y = ~(a & b);
         OP_NOR:   y = ~(a | b);
         OP_XNOR:  y = ~(a ^ b);
         OP_PASSA: y = a;
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshakes and an accumulator.
// Define LOGIC_UNIT_FLAGS_EN to add registered zero/parity flag outputs.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int          WIDTH   = 8,
   parameter logic [63:0] ACC_RST = 64'd0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic             in_acc,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
`ifdef LOGIC_UNIT_FLAGS_EN
   output logic             out_zero,
   output logic             out_par,
`endif
   output logic [WIDTH-1:0] acc_q
);

   localparam logic [WIDTH-1:0] ACC_INIT = ACC_RST[WIDTH-1:0];

   logic             valid_reg;
   logic [WIDTH-1:0] data_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] result;
   logic             accept;

   assign in_ready  = !valid_reg || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_valid = valid_reg;
   assign out_data  = data_reg;
   assign acc_q     = acc_reg;

   // A same-cycle clear is seen by the accumulator read, then the result overwrites it.
   assign b_eff = in_acc ? (acc_clr ? ACC_INIT : acc_reg) : in_b;

   logic_unit_core #(.WIDTH(WIDTH)) u_core (
      .op (op_e'(in_op)),
      .a  (in_a),
      .b  (b_eff),
      .y  (result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
         acc_reg   <= ACC_INIT;
      end else if (accept) begin
         valid_reg <= 1'b1;
         data_reg  <= result;
         acc_reg   <= result;
      end else begin
         if (out_ready) valid_reg <= 1'b0;
         if (acc_clr)   acc_reg   <= ACC_INIT;
      end
   end

`ifdef LOGIC_UNIT_FLAGS_EN
   logic zero_reg;
   logic par_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_reg <= 1'b1;
         par_reg  <= 1'b0;
      end else if (accept) begin
         zero_reg <= (result == '0);
         par_reg  <= ^result;
      end
   end

   assign out_zero = zero_reg;
   assign out_par  = par_reg;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised and directed bench for logic_unit_pipe (WIDTH 8, 1 and 64 instances).
// Reference model evaluates ops from per-op truth tables over (a,b) bit pairs.
module tb_logic_unit_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Truth table per op, indexed by {a_bit, b_bit}.
   logic [3:0] tt_tab [8] = '{4'b0011, 4'b1000, 4'b1110, 4'b0110,
                              4'b0111, 4'b0001, 4'b1001, 4'b1100};
   logic [7:0] sweep_exp [8] = '{8'h0F, 8'hC0, 8'hFC, 8'h3C,
                                 8'h3F, 8'h03, 8'hC3, 8'hF0};

   // WIDTH=8 instance
   logic       in_valid, in_ready, in_acc, acc_clr, out_valid, out_ready;
   logic [2:0] in_op;
   logic [7:0] in_a, in_b, out_data, acc_q;
   logic       out_zero, out_par;

   // WIDTH=1 and WIDTH=64 instances
   logic        w1_valid, w1_ready, w1_acc, w1_ovalid;
   logic [2:0]  w1_op;
   logic [0:0]  w1_a, w1_b, w1_data, w1_accq;
   logic        w64_valid, w64_ready, w64_acc, w64_ovalid;
   logic [2:0]  w64_op;
   logic [63:0] w64_a, w64_b, w64_data, w64_accq;
   logic        w1_zero, w1_par, w64_zero, w64_par;

   logic_unit_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_acc(in_acc), .in_a(in_a), .in_b(in_b),
      .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data),
`ifdef LOGIC_UNIT_FLAGS_EN
      .out_zero(out_zero), .out_par(out_par),
`endif
      .acc_q(acc_q));

   logic_unit_pipe #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(w1_valid), .in_ready(w1_ready),
      .in_op(w1_op), .in_acc(w1_acc), .in_a(w1_a), .in_b(w1_b),
      .acc_clr(1'b0), .out_valid(w1_ovalid), .out_ready(1'b1),
      .out_data(w1_data),
`ifdef LOGIC_UNIT_FLAGS_EN
      .out_zero(w1_zero), .out_par(w1_par),
`endif
      .acc_q(w1_accq));

   logic_unit_pipe #(.WIDTH(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(w64_valid), .in_ready(w64_ready),
      .in_op(w64_op), .in_acc(w64_acc), .in_a(w64_a), .in_b(w64_b),
      .acc_clr(1'b0), .out_valid(w64_ovalid), .out_ready(1'b1),
      .out_data(w64_data),
`ifdef LOGIC_UNIT_FLAGS_EN
      .out_zero(w64_zero), .out_par(w64_par),
`endif
      .acc_q(w64_accq));

   // Model state
   logic        m_valid;
   logic [63:0] m_data, m_acc, m1_acc, m64_acc;

   function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
      logic [3:0]  tt;
      logic [63:0] r;
      r  = '0;
      tt = tt_tab[op];
      for (int i = 0; i < w; i++) r[i] = tt[{a[i], b[i]}];
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of the WIDTH=8 instance, checked against the model.
   task automatic cyc(input logic v, input logic [2:0] op, input logic ac,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic clr, input logic ordy);
      logic        acc_ok;
      logic [63:0] be;
      in_valid = v; in_op = op; in_acc = ac; in_a = a; in_b = b;
      acc_clr = clr; out_ready = ordy;
      #1;
      acc_ok = v && (!m_valid || ordy);
      check("in_ready", 64'(in_ready), 64'(!m_valid || ordy));
      @(posedge clk);
      if (acc_ok) begin
         be = ac ? (clr ? 64'd0 : m_acc) : 64'(b);
         m_data  = ref_op(op, 64'(a), be, 8);
         m_acc   = m_data;
         m_valid = 1'b1;
      end else begin
         if (ordy) m_valid = 1'b0;
         if (clr)  m_acc   = 64'd0;
      end
      #1;
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("out_data", 64'(out_data), m_data);
      check("acc_q", 64'(acc_q), m_acc);
`ifdef LOGIC_UNIT_FLAGS_EN
      check("out_zero", 64'(out_zero), 64'(m_data == 64'd0));
      check("out_par", 64'(out_par), 64'(^m_data));
`endif
      $display("tx v=%0b op=%0d acc=%0b a=%h b=%h clr=%0b ordy=%0b -> valid=%0b data=%h acc_q=%h",
               v, op, ac, a, b, clr, ordy, out_valid, out_data, acc_q);
   endtask

   // One transaction on both wide instances (always accepted, out_ready tied high).
   task automatic wcyc(input logic [2:0] op, input logic ac, input logic a1, input logic b1,
                       input logic [63:0] a64, input logic [63:0] b64);
      logic [63:0] r1, r64;
      w1_valid = 1'b1; w1_op = op; w1_acc = ac; w1_a = a1; w1_b = b1;
      w64_valid = 1'b1; w64_op = op; w64_acc = ac; w64_a = a64; w64_b = b64;
      @(posedge clk);
      r1  = ref_op(op, 64'(a1), ac ? m1_acc : 64'(b1), 1);
      r64 = ref_op(op, a64, ac ? m64_acc : b64, 64);
      m1_acc = r1; m64_acc = r64;
      #1;
      check("w1_valid", 64'(w1_ovalid), 64'd1);
      check("w1_data", 64'(w1_data), r1);
      check("w64_data", w64_data, r64);
      check("w64_acc_q", w64_accq, r64);
      $display("wide op=%0d acc=%0b a1=%0b b1=%0b -> %0b | a64=%h -> %h",
               op, ac, a1, b1, w1_data, a64, w64_data);
   endtask

   task automatic do_reset();
      in_valid = 1'b1; in_op = 3'd7; in_a = 8'h5A; out_ready = 1'b1; acc_clr = 1'b0;
      #2; rst_n = 1'b0; #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_acc_q", 64'(acc_q), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      check("rst_ignore_valid", 64'(out_valid), 64'd0);
      #2; rst_n = 1'b1; in_valid = 1'b0;
      m_valid = 1'b0; m_data = '0; m_acc = '0; m1_acc = '0; m64_acc = '0;
   endtask

   initial begin
      in_valid = 0; in_op = 0; in_acc = 0; in_a = 0; in_b = 0; acc_clr = 0; out_ready = 1;
      w1_valid = 0; w1_op = 0; w1_acc = 0; w1_a = 0; w1_b = 0;
      w64_valid = 0; w64_op = 0; w64_acc = 0; w64_a = 0; w64_b = 0;
      do_reset();
`ifdef LOGIC_UNIT_FLAGS_EN
      check("rst_out_zero", 64'(out_zero), 64'd1);
      check("rst_out_par", 64'(out_par), 64'd0);
`endif

      // Op sweep with continuous ready
      for (int op = 0; op < 8; op++) begin
         cyc(1'b1, 3'(op), 1'b0, 8'hF0, 8'hCC, 1'b0, 1'b1);
         check("sweep_lit", 64'(out_data), 64'(sweep_exp[op]));
      end

      // Backpressure: drain, produce, hold 3 cycles, release
      cyc(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      cyc(1'b1, 3'd1, 1'b0, 8'h3C, 8'h0F, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 3'd3, 1'b0, 8'hAA, 8'h55, 1'b0, 1'b0);
         check("bp_hold", 64'(out_data), 64'h0C);
      end
      cyc(1'b1, 3'd3, 1'b0, 8'hAA, 8'h55, 1'b0, 1'b1);
      check("bp_release", 64'(out_data), 64'hFF);

      // Accumulate chain from reset
      do_reset();
      cyc(1'b1, 3'd2, 1'b1, 8'h01, 8'hEE, 1'b0, 1'b1);
      check("chain1", 64'(acc_q), 64'h01);
      cyc(1'b1, 3'd2, 1'b1, 8'h02, 8'hEE, 1'b0, 1'b1);
      check("chain2", 64'(acc_q), 64'h03);
      cyc(1'b1, 3'd3, 1'b1, 8'hFF, 8'hEE, 1'b0, 1'b1);
      check("chain3", 64'(out_data), 64'hFC);

      // acc_clr collision and standalone clear
      cyc(1'b1, 3'd7, 1'b0, 8'hAA, 8'h00, 1'b0, 1'b1);
      cyc(1'b1, 3'd1, 1'b1, 8'hFF, 8'h77, 1'b1, 1'b1);
      check("clr_collide_data", 64'(out_data), 64'h00);
      cyc(1'b1, 3'd7, 1'b0, 8'h55, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
      check("clr_alone_acc", 64'(acc_q), 64'h00);
      check("clr_alone_data", 64'(out_data), 64'h55);

      // Randomised traffic
      for (int i = 0; i < 300; i++)
         cyc(1'($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom),
             8'($urandom), 8'($urandom), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 3) != 0));

      // Async reset while a result is held
      cyc(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      cyc(1'b1, 3'd7, 1'b0, 8'h81, 8'h00, 1'b0, 1'b0);
      #2; rst_n = 1'b0; #1;
      check("async_valid", 64'(out_valid), 64'd0);
      check("async_acc", 64'(acc_q), 64'd0);
`ifdef LOGIC_UNIT_FLAGS_EN
      check("async_zero", 64'(out_zero), 64'd1);
      check("async_par", 64'(out_par), 64'd0);
`endif
      do_reset();

      // Width sweep: exhaustive at WIDTH=1, random at WIDTH=64
      for (int op = 0; op < 8; op++)
         for (int ab = 0; ab < 4; ab++)
            wcyc(3'(op), 1'b0, 1'(ab >> 1), 1'(ab), {$urandom, $urandom}, {$urandom, $urandom});
      for (int i = 0; i < 24; i++)
         wcyc(3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
